slv_rd_err_responder: RTL
=========================

// Module: slv_rd_err_responder
// PURPOSE
//  Master-side AXI read error responder for the slave guard/monitor. When the monitor declares a read timeout and
//  isolates the downstream slave, it hands each outstanding read's original ID and LEN to this block.
//  The block then completes those reads toward the upstream master with SLVERR bursts of the correct length,
//  so the master never hangs. Sits between the monitor's read tracker and the upstream R-channel mux.
// PARAMETERS
//  IdWidth    6  width of the upstream (non-remapped) AXI ID
//  DataWidth  32 R data width
//  UserWidth  1  R user width
//  FifoDepth  4  queued aborts, in addition to the one burst being served; power of two, >=2
// PORTS
//  clk_i          in  1          clock
//  rst_ni         in  1          asynchronous reset, active low
//  clear_i        in  1          sync flush of queued (not yet started) aborts
//  abort_valid_i  in  1          abort request valid
//  abort_ready_o  out 1          abort request accepted (= !fifo_full)
//  abort_id_i     in  IdWidth    ID of the read to terminate
//  abort_len_i    in  8          AXI LEN of that read (beats-1)
//  r_valid_o      out 1          R valid to master
//  r_ready_i      in  1          R ready from master
//  r_id_o         out IdWidth    R ID
//  r_data_o       out DataWidth  R data, always 0
//  r_resp_o       out 2          always axi_pkg::RESP_SLVERR (2'b10) while valid
//  r_last_o       out 1          last beat of current burst
//  r_user_o       out UserWidth  always 0
//  pending_o      out $clog2(FifoDepth+2)  queued entries + (state==BURST)
// BEHAVIOUR
//  Reset (async): FIFO empty, state IDLE; r_valid_o=0, r_last_o=0, r_id_o=0, r_resp_o=0, pending_o=0.
//  Abort handshake: abort_valid_i & abort_ready_o at edge N writes {id,len} to the FIFO (no fall-through).
//  FSM IDLE: if FIFO non-empty, pop head; at next edge load cur_id, beat_cnt=len; go BURST.
//   Net latency: abort accepted at edge N into empty block -> r_valid_o=1 from edge N+1.
//  FSM BURST: r_valid_o=1, r_id_o=cur_id, r_resp_o=SLVERR, r_last_o=(beat_cnt==0).
//   Handshake (r_valid_o & r_ready_i), not last: beat_cnt-=1.
//   Handshake on last: if FIFO non-empty, pop and load next in the same edge (no bubble, stay BURST); else IDLE.
//   No handshake: all R outputs held stable (AXI: valid never dropped, payload never changed).
//  beat_cnt is 8 bits, counts down; len=255 -> exactly 256 beats; never wraps below 0.
//  Full: abort_ready_o=0 while FIFO full, even if a pop happens the same cycle (no push-through on full).
//  Empty FIFO push and pop in same cycle impossible (no fall-through); push+pop on non-full non-empty both occur.
//  clear_i: empties FIFO at next edge; a burst already in BURST completes all remaining beats.
//   clear_i has priority over a simultaneous push (the pushed entry is dropped; abort_ready_o stays as computed).
//  pending_o counts entries accepted but not fully answered; decrements on the last-beat handshake.
//  Reset mid-burst: r_valid_o drops asynchronously; in-flight burst is abandoned (upstream reset assumed common).
// STRUCTURE
//  slv_pkg additions:
//   typedef struct packed {id_t id; axi_pkg::len_t len;} rd_abort_t
//   typedef enum logic {ERR_IDLE, ERR_BURST} err_rsp_state_t
//  Queue uses the existing common_cells fifo_v3 (FALL_THROUGH=0, DEPTH=FifoDepth, type rd_abort_t).
//  No new sub-module. A write-side twin (B channel, single beat) reuses the same package type.
// TESTING
//  1 abort id=5 len=3, r_ready=1 -> 4 consecutive beats rid=5 resp=2'b10 data=0, r_last only on 4th;
//    r_valid rises 1 edge after accept; pending 1->0 after beat 4.
//  2 id=7 len=2, r_ready low 3 cycles after beat 1 -> r_valid/rid/r_last stable through stall, 3 beats total.
//  3 r_ready=0, push aborts id=0..5 -> 5 accepted (1 in BURST + 4 queued), 6th sees abort_ready_o=0, pending_o=5.
//    Release r_ready -> bursts in order 0..4, then id=5 is accepted.
//  4 queue {id=1,len=0},{id=2,len=1}, r_ready=1 -> id1(last), id2, id2(last) on 3 consecutive cycles, no bubble.
//  5 id=9 len=255 -> exactly 256 beats, r_last only on 256th, state returns IDLE.
//  6 clear_i during beat 2 of a len=3 burst with 2 queued -> burst ends after 4 beats, no further beats, pending_o=0.
//    Repeat with rst_ni low mid-burst -> r_valid_o=0 immediately, pending_o=0.

Source files
------------

// File: rtl/slv_rd_err_responder_pkg.sv
// Shared types and constants for the read error responder.
// Contents:
//   len_t         AXI burst length (beats-1)
//   resp_t        AXI response code
//   RespOkay      response driven while R is idle
//   RespSlverr    response driven on every error beat
//   StIdle        FSM state: no burst being answered
//   StBurst       FSM state: driving beats of one burst
//   is_last_beat  true when the beat counter says this is the final beat
package slv_rd_err_responder_pkg;

  typedef logic [7:0] len_t;
  typedef logic [1:0] resp_t;

  localparam resp_t RespOkay   = 2'b00;
  localparam resp_t RespSlverr = 2'b10;

  localparam logic StIdle  = 1'b0;
  localparam logic StBurst = 1'b1;

  function automatic logic is_last_beat(input len_t beats_left);
    return beats_left == '0;
  endfunction

endpackage

// File: rtl/slv_rd_err_responder.sv
// Completes reads of an isolated slave toward the upstream master with SLVERR bursts
// of the original length, so the master never hangs.
// Ports:
//   clk_i, rst_ni       clock and asynchronous active-low reset
//   clear_i             flush queued aborts that have not started yet
//   abort_valid_i/ready_o, abort_id_i, abort_len_i
//                       abort request for one outstanding read
//   r_valid_o/r_ready_i, r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o
//                       upstream R channel
//   pending_o           aborts accepted but not yet fully answered
module slv_rd_err_responder
  import slv_rd_err_responder_pkg::*;
#(
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              abort_valid_i,
  output logic                              abort_ready_o,
  input  logic [IdWidth-1:0]                abort_id_i,
  input  logic [7:0]                        abort_len_i,
  output logic                              r_valid_o,
  input  logic                              r_ready_i,
  output logic [IdWidth-1:0]                r_id_o,
  output logic [DataWidth-1:0]              r_data_o,
  output logic [1:0]                        r_resp_o,
  output logic                              r_last_o,
  output logic [UserWidth-1:0]              r_user_o,
  output logic [$clog2(FifoDepth+2)-1:0]    pending_o
);

  localparam int unsigned PtrWidth  = $clog2(FifoDepth);
  localparam int unsigned CntWidth  = $clog2(FifoDepth + 1);
  localparam int unsigned PendWidth = $clog2(FifoDepth + 2);

  typedef struct packed {
    logic [IdWidth-1:0] id;
    len_t               len;
  } rd_abort_t;

  rd_abort_t             mem_q [FifoDepth];
  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  full, empty, push, pop;

  logic                  state_q, state_d;
  logic [IdWidth-1:0]    cur_id_q, cur_id_d;
  len_t                  beat_cnt_q, beat_cnt_d;
  logic                  busy, r_hs, last_hs;
  rd_abort_t             head;

  assign full  = cnt_q == CntWidth'(FifoDepth);
  assign empty = cnt_q == '0;
  assign head  = mem_q[rd_ptr_q];

  assign busy    = state_q == StBurst;
  assign r_hs    = busy & r_ready_i;
  assign last_hs = r_hs & is_last_beat(beat_cnt_q);

  // Ready ignores a same-cycle pop: no push-through while full.
  assign push = abort_valid_i & ~full & ~clear_i;
  // A flush also cancels the pop, so nothing queued starts after clear_i.
  assign pop  = ~clear_i & ~empty & (~busy | last_hs);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(FifoDepth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (clear_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= '{id: abort_id_i, len: abort_len_i};
          wr_ptr_q        <= wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      // Covers both the idle start and the back-to-back reload on a last beat.
      state_d    = StBurst;
      cur_id_d   = head.id;
      beat_cnt_d = head.len;
    end else if (last_hs) begin
      state_d = StIdle;
    end else if (r_hs) begin
      beat_cnt_d = beat_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cur_id_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign abort_ready_o = ~full;
  assign r_valid_o     = busy;
  assign r_id_o        = cur_id_q;
  assign r_data_o      = '0;
  assign r_resp_o      = busy ? RespSlverr : RespOkay;
  assign r_last_o      = busy & is_last_beat(beat_cnt_q);
  assign r_user_o      = '0;
  assign pending_o     = PendWidth'(cnt_q) + PendWidth'(busy);

endmodule
